mux_sel_arb: RTL and testbench

Round-robin packet arbiter that drives the select input of the 2:1 mux stage and gates its output with a valid/ready handshake. Two upstream sources present beats with a `last` marker. The block grants one source at a time and holds the grant until that source's last beat is accepted downstream. `sel` feeds the mux select directly. The mux data path stays outside this block.

---
 rtl/mux_sel_arb_if.sv | 26 ++
 rtl/mux_sel_arb.sv | 131 +++++++++++++
 tb/tb_mux_sel_arb.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mux_sel_arb_if.sv
// Handshake bundle between two packet sources, the downstream sink and the
// round-robin arbiter that steers the 2:1 mux select.
interface mux_sel_arb_if;
  logic req0_valid;
  logic req0_last;
  logic req0_ready;
  logic req1_valid;
  logic req1_last;
  logic req1_ready;
  logic out_valid;
  logic out_last;
  logic out_ready;
  logic sel;
  logic busy;
  logic timeout;

  modport master (
    output req0_valid, req0_last, req1_valid, req1_last, out_ready,
    input  req0_ready, req1_ready, out_valid, out_last, sel, busy, timeout
  );

  modport slave (
    input  req0_valid, req0_last, req1_valid, req1_last, out_ready,
    output req0_ready, req1_ready, out_valid, out_last, sel, busy, timeout
  );
endinterface

// File: rtl/mux_sel_arb.sv
// Round-robin packet arbiter driving a 2:1 mux select; grant held until last beat.
// Optional forced release after MAX_BEATS beats: define MUX_SEL_ARB_TIMEOUT_EN.
module mux_sel_arb #(
  parameter int MAX_BEATS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_sel_arb_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;
  localparam logic [7:0] L_MAX   = 8'(MAX_BEATS);

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       r_last_gnt;
  logic       w_last_gnt_next;
  logic       r_sel;
  logic       w_out_valid;
  logic       w_out_last;
  logic       w_accept;
  logic       w_force;
  logic       w_release;

  always_comb begin
    w_out_valid    = 1'b0;
    w_out_last     = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (r_state)
      ST_GNT0: begin
        w_out_valid    = bus.req0_valid;
        w_out_last     = bus.req0_last;
        bus.req0_ready = bus.out_ready;
      end
      ST_GNT1: begin
        w_out_valid    = bus.req1_valid;
        w_out_last     = bus.req1_last;
        bus.req1_ready = bus.out_ready;
      end
      default: ;
    endcase
  end

  assign w_accept      = w_out_valid && bus.out_ready;
  assign w_release     = w_accept && (w_out_last || w_force);
  assign bus.out_valid = w_out_valid;
  assign bus.out_last  = w_out_last;
  assign bus.sel       = r_sel;
  assign bus.busy      = (r_state != ST_IDLE);

`ifdef MUX_SEL_ARB_TIMEOUT_EN
  logic [7:0] r_beat_cnt;
  logic [7:0] w_cnt_inc;
  logic       r_timeout;

  assign w_cnt_inc   = r_beat_cnt + 8'd1;
  assign w_force     = w_accept && !w_out_last && (w_cnt_inc == L_MAX);
  assign bus.timeout = r_timeout;

  // Only a release can change the grant, so clearing on release covers handoffs too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_force;
      if (w_release)
        r_beat_cnt <= 8'd0;
      else if (w_accept)
        r_beat_cnt <= w_cnt_inc;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^L_MAX;
  assign w_force      = 1'b0;
  assign bus.timeout  = 1'b0;
`endif

  always_comb begin
    w_state_next    = r_state;
    w_last_gnt_next = r_last_gnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.req0_valid && bus.req1_valid)
          w_state_next = r_last_gnt ? ST_GNT0 : ST_GNT1;
        else if (bus.req0_valid)
          w_state_next = ST_GNT0;
        else if (bus.req1_valid)
          w_state_next = ST_GNT1;
      end
      ST_GNT0: begin
        if (w_release) begin
          w_last_gnt_next = 1'b0;
          if (bus.req1_valid)      w_state_next = ST_GNT1;
          else if (bus.req0_valid) w_state_next = ST_GNT0;
          else                     w_state_next = ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (w_release) begin
          w_last_gnt_next = 1'b1;
          if (bus.req0_valid)      w_state_next = ST_GNT0;
          else if (bus.req1_valid) w_state_next = ST_GNT1;
          else                     w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // sel is registered alongside the state and simply holds while IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= 1'b1;
      r_sel      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_last_gnt <= w_last_gnt_next;
      if (w_state_next == ST_GNT0)
        r_sel <= 1'b0;
      else if (w_state_next == ST_GNT1)
        r_sel <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_sel_arb.sv
// Randomized and directed bench for mux_sel_arb against a grant-owner reference model.
module tb_mux_sel_arb;
  localparam int MAX_B = 4;
`ifdef MUX_SEL_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  mux_sel_arb_if bus ();
  mux_sel_arb #(.MAX_BEATS(MAX_B)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Reference: which source owns the grant (-1 none), the round-robin pointer,
  // the beats taken in this grant and the last mux select driven.
  int m_owner;
  bit m_ptr;
  bit m_sel;
  bit m_to;
  int m_cnt;
  int cyc_no = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 1'b1;
    m_sel   = 1'b0;
    m_to    = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic cyc(input bit v0, input bit l0, input bit v1, input bit l1, input bit rdy,
                     output bit a0, output bit a1);
    bit vv[2];
    bit ll[2];
    bit e_ov, e_ol, acc, frc;
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_last = l0;
    bus.req1_valid = v1; bus.req1_last = l1;
    bus.out_ready  = rdy;
    #1;
    vv[0] = v0; vv[1] = v1; ll[0] = l0; ll[1] = l1;
    e_ov = (m_owner >= 0) ? vv[m_owner] : 1'b0;
    e_ol = (m_owner >= 0) ? ll[m_owner] : 1'b0;
    cyc_no++;
    check($sformatf("c%0d sel", cyc_no), 32'(bus.sel), 32'(m_sel));
    check($sformatf("c%0d busy", cyc_no), 32'(bus.busy), 32'(m_owner >= 0));
    check($sformatf("c%0d out_valid", cyc_no), 32'(bus.out_valid), 32'(e_ov));
    check($sformatf("c%0d out_last", cyc_no), 32'(bus.out_last), 32'(e_ol));
    check($sformatf("c%0d ready0", cyc_no), 32'(bus.req0_ready), 32'(m_owner == 0 && rdy));
    check($sformatf("c%0d ready1", cyc_no), 32'(bus.req1_ready), 32'(m_owner == 1 && rdy));
    check($sformatf("c%0d timeout", cyc_no), 32'(bus.timeout), 32'(m_to));
    a0 = bus.req0_ready && v0;
    a1 = bus.req1_ready && v1;
    @(posedge clk);
    acc  = (m_owner >= 0) && e_ov && rdy;
    frc  = TO_EN && acc && !e_ol && (m_cnt + 1 == MAX_B);
    m_to = frc;
    if (m_owner < 0) begin
      if (v0 && v1)  m_owner = m_ptr ? 0 : 1;
      else if (v0)   m_owner = 0;
      else if (v1)   m_owner = 1;
    end else if (acc && (e_ol || frc)) begin
      m_ptr = m_owner[0];
      if (vv[1 - m_owner])  m_owner = 1 - m_owner;
      else if (!vv[m_owner]) m_owner = -1;
      m_cnt = 0;
    end else if (acc) begin
      m_cnt++;
    end
    if (m_owner >= 0) m_sel = m_owner[0];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req0_valid = 0; bus.req0_last = 0;
    bus.req1_valid = 0; bus.req1_last = 0;
    bus.out_ready  = 0;
    #1;
    check("rst sel", 32'(bus.sel), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst ready0", 32'(bus.req0_ready), 32'd0);
    check("rst ready1", 32'(bus.req1_ready), 32'd0);
    check("rst timeout", 32'(bus.timeout), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit a0, a1;
    int b0, b1, beats0;
    bit sel_seq[$];

    model_reset();
    do_reset();

    // Both sources with 3-beat packets: source 0 first, then source 1 without a bubble.
    b0 = 0; b1 = 0;
    cyc(1, 0, 1, 0, 1, a0, a1);
    for (int i = 0; i < 6; i++) begin
      cyc(1, b0 == 2, 1, b1 == 2, 1, a0, a1);
      sel_seq.push_back(bus.sel);
      if (a0) b0 = (b0 + 1) % 3;
      if (a1) b1 = (b1 + 1) % 3;
    end
    for (int i = 0; i < 6; i++)
      check($sformatf("seq sel[%0d]", i), 32'(sel_seq[i]), 32'(i >= 3));

    // Only source 1, single-beat packets back to back.
    do_reset();
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 1, 1, a0, a1);

    // Downstream stall mid-packet, then a source-0 valid drop while source 1 waits.
    do_reset();
    cyc(1, 0, 1, 0, 1, a0, a1);
    cyc(1, 0, 1, 0, 1, a0, a1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 0, a0, a1);
    cyc(0, 0, 1, 0, 1, a0, a1);
    cyc(0, 0, 1, 0, 1, a0, a1);
    cyc(1, 1, 1, 0, 1, a0, a1);
    cyc(0, 0, 1, 1, 1, a0, a1);

    // Source 0 streams without last while source 1 is waiting.
    do_reset();
    beats0 = 0;
    for (int i = 0; i < 11; i++) begin
      cyc(1, 0, 1, 0, 1, a0, a1);
      if (a0) beats0++;
    end
    check("long pkt src0 beats", 32'(beats0), TO_EN ? 32'd6 : 32'd10);

    // Async reset in the middle of a source-1 packet, with no clock edge.
    do_reset();
    cyc(0, 0, 1, 0, 1, a0, a1);
    cyc(0, 0, 1, 0, 1, a0, a1);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst sel", 32'(bus.sel), 32'd0);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst ready1", 32'(bus.req1_ready), 32'd0);
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 3) != 0, a0, a1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
